// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter in front of the single-port data memory
// Core has priority. A host that has waited MAX_WAIT cycles overrides it, and host lock bursts are capped at LOCK_MAX grants.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_we,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        core_stall,
  input  logic        h_req,
  input  logic        h_lock,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  input  logic [3:0]  h_we,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);
  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  logic       lock_q, lock_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       force_core_q, force_core_d;
  logic       rsel_q, rsel_d;
  logic       rpend_q, rpend_d;

  logic       grant_c, grant_h;
  logic [7:0] lock_cnt_inc;
  logic       lock_break;

  always_comb begin
    grant_c = 1'b0;
    grant_h = 1'b0;
    if (!reset) begin
      if (force_core_q && c_req) begin
        grant_c = 1'b1;
      end else if (lock_q && h_req) begin
        grant_h = 1'b1;
      end else if (h_req && (wait_cnt_q == WaitMax)) begin
        grant_h = 1'b1;
      end else if (c_req) begin
        grant_c = 1'b1;
      end else if (h_req) begin
        grant_h = 1'b1;
      end
    end
  end

  assign c_gnt      = grant_c;
  assign h_gnt      = grant_h;
  assign core_stall = c_req & ~grant_c;

  always_comb begin
    m_addr  = grant_h ? h_addr  : c_addr;
    m_wdata = grant_h ? h_wdata : c_wdata;
    if (grant_h) begin
      m_we = h_we;
    end else if (grant_c) begin
      m_we = c_we;
    end else begin
      m_we = 4'b0000;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_h || !h_req) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // lock_cnt counts every grant of the burst, including the one that enters the lock
  assign lock_cnt_inc = lock_cnt_q + 8'd1;
  assign lock_break   = grant_h & h_lock & (lock_cnt_inc == LockMax);

  always_comb begin
    lock_d = lock_q;
    if (grant_h) begin
      lock_d = h_lock & ~lock_break;
    end else if (!h_req) begin
      lock_d = 1'b0;
    end

    lock_cnt_d = 8'd0;
    if (lock_d) begin
      lock_cnt_d = grant_h ? lock_cnt_inc : lock_cnt_q;
    end

    force_core_d = lock_break;
  end

  always_comb begin
    rpend_d = (grant_c && (c_we == 4'b0000)) || (grant_h && (h_we == 4'b0000));
    rsel_d  = grant_h;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      wait_cnt_q   <= 4'd0;
      lock_cnt_q   <= 8'd0;
      force_core_q <= 1'b0;
      rsel_q       <= 1'b0;
      rpend_q      <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      force_core_q <= force_core_d;
      rsel_q       <= rsel_d;
      rpend_q      <= rpend_d;
    end
  end

  // A read still in flight when reset rises must not report valid data
  assign c_rvalid = rpend_q & ~rsel_q & ~reset;
  assign h_rvalid = rpend_q &  rsel_q & ~reset;
  assign c_rdata  = m_rdata;
  assign h_rdata  = m_rdata;

endmodule
